// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared clock mode encodings, time limits and wrap helpers
package clock_pkg;

    // Mode encoding shared with the alarm logic; value 3 is never produced.
    typedef enum logic [1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_HOUR = 2'd1,
        MODE_SET_MIN  = 2'd2
    } mode_e;

    localparam logic [5:0] SEC_MAX = 6'd59;
    localparam logic [5:0] MIN_MAX = 6'd59;

    // Width of the hour/minute/second output buses.
    localparam int TIME_W = 11;

    // Increment a seconds/minutes field, wrapping to zero after max.
    function automatic logic [5:0] wrap_inc6(input logic [5:0] v, input logic [5:0] max);
        return (v == max) ? 6'd0 : v + 6'd1;
    endfunction

    // Increment the hour field, wrapping to zero after max.
    function automatic logic [4:0] wrap_inc5(input logic [4:0] v, input logic [4:0] max);
        return (v == max) ? 5'd0 : v + 5'd1;
    endfunction

    // Mode sequence stepped by the middle button.
    function automatic mode_e next_mode(input mode_e m);
        case (m)
            MODE_RUN:      return MODE_SET_HOUR;
            MODE_SET_HOUR: return MODE_SET_MIN;
            default:       return MODE_RUN;
        endcase
    endfunction

endpackage

// File: rtl/btn_edge.sv
// rtl/btn_edge.sv - rising-edge detector for a debounced button level
module btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic pulse
);

    logic prev;
    logic armed;

    // Track the previous level; 'armed' suppresses the first sample after
    // reset so a button held through reset release is not seen as a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev  <= 1'b0;
            armed <= 1'b0;
        end else begin
            prev  <= level;
            armed <= 1'b1;
        end
    end

    assign pulse = armed & level & ~prev;

endmodule

// File: rtl/time_counter.sv
// rtl/time_counter.sv - hh:mm:ss clock with run / set-hour / set-minute modes
module time_counter
    import clock_pkg::*;
#(
    parameter int HOURS_PER_DAY = 24
) (
    input  logic              newclk,
    input  logic              rst_n,
    input  logic              tick_1hz,
    input  logic              middle,
    input  logic              up,
    output logic [TIME_W-1:0] hour,
    output logic [TIME_W-1:0] minute,
    output logic [TIME_W-1:0] second,
    output logic [1:0]        set_mode,
    output logic              min_pulse
);

    localparam logic [4:0] HOUR_MAX = 5'(HOURS_PER_DAY - 1);

    mode_e      mode;
    logic [4:0] hour_q;
    logic [5:0] min_q;
    logic [5:0] sec_q;
    logic       min_pulse_q;

    logic middle_evt;
    logic up_evt;

    btn_edge u_middle_edge (
        .clk   (newclk),
        .rst_n (rst_n),
        .level (middle),
        .pulse (middle_evt)
    );

    btn_edge u_up_edge (
        .clk   (newclk),
        .rst_n (rst_n),
        .level (up),
        .pulse (up_evt)
    );

    // Mode FSM and the sec->min->hour cascade in one register stage. A mode
    // change always wins: a tick or up press in the same cycle is dropped.
    always_ff @(posedge newclk or negedge rst_n) begin
        if (!rst_n) begin
            mode        <= MODE_RUN;
            hour_q      <= 5'd0;
            min_q       <= 6'd0;
            sec_q       <= 6'd0;
            min_pulse_q <= 1'b0;
        end else begin
            min_pulse_q <= 1'b0;
            case (mode)
                MODE_RUN: begin
                    if (middle_evt) begin
                        mode  <= next_mode(mode);
                        sec_q <= 6'd0;
                    end else if (tick_1hz) begin
                        sec_q <= wrap_inc6(sec_q, SEC_MAX);
                        if (sec_q == SEC_MAX) begin
                            min_q       <= wrap_inc6(min_q, MIN_MAX);
                            min_pulse_q <= 1'b1;
                            if (min_q == MIN_MAX) begin
                                hour_q <= wrap_inc5(hour_q, HOUR_MAX);
                            end
                        end
                    end
                end
                MODE_SET_HOUR: begin
                    if (middle_evt) begin
                        mode <= next_mode(mode);
                    end else if (up_evt) begin
                        hour_q <= wrap_inc5(hour_q, HOUR_MAX);
                    end
                end
                MODE_SET_MIN: begin
                    if (middle_evt) begin
                        mode <= next_mode(mode);
                    end else if (up_evt) begin
                        min_q <= wrap_inc6(min_q, MIN_MAX);
                    end
                end
                default: begin
                    mode <= MODE_RUN;
                end
            endcase
        end
    end

    assign hour      = {6'd0, hour_q};
    assign minute    = {5'd0, min_q};
    assign second    = {5'd0, sec_q};
    assign set_mode  = mode;
    assign min_pulse = min_pulse_q;

endmodule

// File: tb/tb_time_counter.sv
// tb/tb_time_counter.sv - self-checking bench for time_counter
module tb_time_counter;

    localparam int HPD = 24;
    localparam int DAY = HPD * 3600;

    logic        newclk;
    logic        rst_n;
    logic        tick_1hz;
    logic        middle;
    logic        up;
    logic [10:0] hour;
    logic [10:0] minute;
    logic [10:0] second;
    logic [1:0]  set_mode;
    logic        min_pulse;

    int n_vec;
    int n_err;
    bit chk_en;
    int pulse_cnt;

    // Model: time as seconds since midnight, mode as 0/1/2, last button levels.
    int m_t;
    int m_mode;
    bit m_pulse;
    bit m_pm;
    bit m_pu;

    time_counter #(.HOURS_PER_DAY(HPD)) dut (
        .newclk    (newclk),
        .rst_n     (rst_n),
        .tick_1hz  (tick_1hz),
        .middle    (middle),
        .up        (up),
        .hour      (hour),
        .minute    (minute),
        .second    (second),
        .set_mode  (set_mode),
        .min_pulse (min_pulse)
    );

    initial newclk = 1'b0;
    always #5 newclk = ~newclk;

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        n_vec++;
        if (act !== 32'(exp)) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Levels seen before the first post-reset edge count as already high.
    task automatic model_reset();
        m_t     = 0;
        m_mode  = 0;
        m_pulse = 0;
        m_pm    = 1;
        m_pu    = 1;
    endtask

    task automatic model_step(input bit t, input bit m, input bit u);
        bit me, ue;
        int h, mi, s;
        me      = m && !m_pm;
        ue      = u && !m_pu;
        m_pm    = m;
        m_pu    = u;
        m_pulse = 0;
        h  = m_t / 3600;
        mi = (m_t / 60) % 60;
        s  = m_t % 60;
        if (m_mode == 0) begin
            if (me) begin
                m_mode = 1;
                m_t    = m_t - s;
            end else if (t) begin
                m_pulse = (s == 59);
                m_t     = (m_t + 1) % DAY;
            end
        end else if (m_mode == 1) begin
            if (me) m_mode = 2;
            else if (ue) m_t = ((h + 1) % HPD) * 3600 + mi * 60 + s;
        end else begin
            if (me) m_mode = 0;
            else if (ue) m_t = h * 3600 + ((mi + 1) % 60) * 60 + s;
        end
    endtask

    always @(negedge newclk) begin
        if (chk_en) begin
            chk("hour",      32'(hour),      m_t / 3600);
            chk("minute",    32'(minute),    (m_t / 60) % 60);
            chk("second",    32'(second),    m_t % 60);
            chk("set_mode",  32'(set_mode),  m_mode);
            chk("min_pulse", 32'(min_pulse), int'(m_pulse));
        end
    end

    task automatic cyc(input bit t, input bit m, input bit u);
        tick_1hz = t;
        middle   = m;
        up       = u;
        @(posedge newclk);
        model_step(t, m, u);
        @(negedge newclk);
        if (min_pulse === 1'b1) pulse_cnt++;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            cyc(1, 0, 0);
            cyc(0, 0, 0);
        end
    endtask

    task automatic press_mid();
        cyc(0, 1, 0);
        cyc(0, 0, 0);
    endtask

    task automatic press_up(input int n);
        repeat (n) begin
            cyc(0, 0, 1);
            cyc(0, 0, 0);
        end
    endtask

    task automatic chk_time(input string name, input int h, input int mi, input int s);
        chk({name, "_h"}, 32'(hour),   h);
        chk({name, "_m"}, 32'(minute), mi);
        chk({name, "_s"}, 32'(second), s);
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        chk_en    = 0;
        pulse_cnt = 0;
        tick_1hz  = 0;
        middle    = 0;
        up        = 0;
        rst_n     = 1;
        model_reset();
        #1 rst_n = 0;
        #1;
        chk_time("rst", 0, 0, 0);
        chk("rst_mode", 32'(set_mode), 0);
        chk("rst_pulse", 32'(min_pulse), 0);
        chk_en = 1;
        @(negedge newclk);
        @(negedge newclk);
        rst_n = 1;

        // 60 ticks from reset: one minute, one pulse
        pulse_cnt = 0;
        ticks(60);
        chk_time("min1", 0, 1, 0);
        chk("min1_pulses", 32'(pulse_cnt), 1);

        // preload 23:59:58 then roll past midnight
        press_mid();
        press_up(23);
        press_mid();
        press_up(58);
        press_mid();
        chk("preload_mode", 32'(set_mode), 0);
        ticks(58);
        chk_time("pre", 23, 59, 58);
        cyc(1, 0, 0);
        chk_time("t59", 23, 59, 59);
        chk("t59_pulse", 32'(min_pulse), 0);
        cyc(0, 0, 0);
        cyc(1, 0, 0);
        chk_time("mid", 0, 0, 0);
        chk("mid_pulse", 32'(min_pulse), 1);
        cyc(0, 0, 0);

        // 10:20:35 -> SET_HOUR clears seconds, three ups, ticks ignored
        press_mid();
        press_up(10);
        press_mid();
        press_up(20);
        press_mid();
        ticks(35);
        chk_time("p34", 10, 20, 35);
        cyc(0, 1, 0);
        chk("p34_mode", 32'(set_mode), 1);
        chk("p34_sec", 32'(second), 0);
        cyc(0, 0, 0);
        press_up(3);
        chk("p34_h13", 32'(hour), 13);
        ticks(5);
        chk_time("p34_hold", 13, 20, 0);

        // SET_MIN wrap 59 -> 0 without hour carry
        press_mid();
        press_up(39);
        chk("p35_m59", 32'(minute), 59);
        press_up(1);
        chk_time("p35_wrap", 13, 0, 0);
        press_mid();
        chk("p35_mode", 32'(set_mode), 0);

        // middle+up together in RUN; then up held 10 cycles
        cyc(0, 1, 1);
        chk("p36_mode", 32'(set_mode), 1);
        chk("p36_hour", 32'(hour), 13);
        cyc(0, 0, 0);
        repeat (10) cyc(0, 0, 1);
        cyc(0, 0, 0);
        chk("p36_held", 32'(hour), 14);

        // tick and middle together in RUN
        press_mid();
        press_mid();
        ticks(3);
        chk_time("p24_pre", 14, 0, 3);
        cyc(1, 1, 0);
        chk("p24_mode", 32'(set_mode), 1);
        chk("p24_sec", 32'(second), 0);
        cyc(0, 0, 0);

        // reach 07:45:00 in SET_MIN, reset mid-cycle with middle held
        press_up(17);
        press_mid();
        press_up(45);
        chk_time("p37_pre", 7, 45, 0);
        chk("p37_pre_mode", 32'(set_mode), 2);
        #2;
        rst_n  = 0;
        middle = 1;
        model_reset();
        #1;
        chk_time("p37_rst", 0, 0, 0);
        chk("p37_rst_mode", 32'(set_mode), 0);
        @(negedge newclk);
        rst_n = 1;
        repeat (3) cyc(0, 1, 0);
        chk("p28_mode", 32'(set_mode), 0);
        cyc(1, 1, 0);
        chk("p27_sec", 32'(second), 1);
        chk("p27_mode", 32'(set_mode), 0);
        cyc(0, 0, 0);

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
